// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// dmem_responder_if : pipeline <-> data-memory request/response bundle
// Rev 1.0
// ============================================================================
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Stall;
  logic        Done;
  logic        AccessErr;

  modport master (
    output MemRead, MemWrite, Funct3, Addr, WData,
    input  RData, Stall, Done, AccessErr
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, Addr, WData,
    output RData, Stall, Done, AccessErr
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : fixed-latency load/store target with byte/half/word access
// Rev 1.0
// ============================================================================
module dmem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [31:0]         mem [2**ADDR_W];

  logic                req;
  logic                cur_rd, cur_wr;
  logic [2:0]          cur_f3;
  logic [ADDR_W+1:0]   cur_addr;
  logic [31:0]         cur_wdata;
  logic [ADDR_W-1:0]   cur_idx;
  logic [31:0]         cur_word;
  logic [7:0]          cur_byte;
  logic [15:0]         cur_half;
  logic                acc_err;
  logic [31:0]         load_val;
  logic [3:0]          wr_be;
  logic [31:0]         wr_word;
  logic                enter_done;
  logic                unused_addr_hi;

  assign req            = bus.MemRead | bus.MemWrite;
  assign unused_addr_hi = ^bus.Addr[31:ADDR_W+2];

  // In IDLE the live inputs describe the access (needed when LATENCY=1);
  // afterwards the latched copy is authoritative.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_rd    = bus.MemRead;
      cur_wr    = bus.MemWrite;
      cur_f3    = bus.Funct3;
      cur_addr  = bus.Addr[ADDR_W+1:0];
      cur_wdata = bus.WData;
    end else begin
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_f3    = f3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign cur_idx  = cur_addr[ADDR_W+1:2];
  assign cur_word = mem[cur_idx];
  assign cur_half = cur_addr[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    case (cur_addr[1:0])
      2'd0:    cur_byte = cur_word[7:0];
      2'd1:    cur_byte = cur_word[15:8];
      2'd2:    cur_byte = cur_word[23:16];
      default: cur_byte = cur_word[31:24];
    endcase
  end

  always_comb begin
    acc_err = cur_rd & cur_wr;
    case (cur_f3)
      F3_B, F3_BU: ;
      F3_H, F3_HU: acc_err = acc_err | cur_addr[0];
      F3_W:        acc_err = acc_err | (cur_addr[1:0] != 2'b00);
      default:     acc_err = 1'b1;
    endcase
    if (cur_wr && cur_f3[2]) acc_err = 1'b1;
  end

  always_comb begin
    case (cur_f3)
      F3_B:    load_val = {{24{cur_byte[7]}}, cur_byte};
      F3_BU:   load_val = {24'd0, cur_byte};
      F3_H:    load_val = {{16{cur_half[15]}}, cur_half};
      F3_HU:   load_val = {16'd0, cur_half};
      F3_W:    load_val = cur_word;
      default: load_val = 32'd0;
    endcase
  end

  // Store data replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    case (cur_f3)
      F3_B: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_word = {4{cur_wdata[7:0]}};
      end
      F3_H: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{cur_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_word = cur_wdata;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          rd_d    = bus.MemRead;
          wr_d    = bus.MemWrite;
          f3_d    = bus.Funct3;
          addr_d  = bus.Addr[ADDR_W+1:0];
          wdata_d = bus.WData;
          cnt_d   = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = enter_done;
    err_d  = enter_done & acc_err;
    if (enter_done) begin
      if (acc_err)     rdata_d = 32'd0;
      else if (cur_rd) rdata_d = load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Reset forces state_q to IDLE asynchronously, so an interrupted store never commits.
  always_ff @(posedge clk) begin
    if (state_q == S_DONE && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[cur_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign bus.Stall     = rst_n & (((state_q == S_IDLE) & req) | (state_q == S_BUSY));
  assign bus.Done      = done_q;
  assign bus.AccessErr = err_q;
  assign bus.RData     = rdata_q;

endmodule
`default_nettype wire
